div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
- Shares the single multi-cycle divider unit between two requesters, for example the ALU issue path and the test/debug port.
- Arbitrates round-robin and drives the divider's start/operand interface.
- Waits for divider done, then captures quotient/remainder and returns a tagged response pulse to the winning requester.
- Screens divide-by-zero without touching the divider; an optional watchdog aborts hung operations.

Parameters:
- WIDTH, 16, operand/quotient/remainder width (divider is a 16-iteration unit).
- TIMEOUT, 40, maximum WAIT cycles before abort (optional feature only); must be > 18.

Ports:
- clk  in  1  system clock, rising edge.
- reset_a_n  in  1  asynchronous reset, active-low.
- req  in  2  per-requester request level; held with operands stable until own rsp_valid.
- dividend0  in  WIDTH  requester 0 dividend.
- divisor0  in  WIDTH  requester 0 divisor.
- dividend1  in  WIDTH  requester 1 dividend.
- divisor1  in  WIDTH  requester 1 divisor.
- gnt  out  2  one-hot grant; held from ISSUE through RESP.
- rsp_valid  out  2  one-cycle response pulse to the granted requester.
- rsp_quot  out  WIDTH  quotient; valid with rsp_valid.
- rsp_rem  out  WIDTH  remainder; valid with rsp_valid.
- rsp_err  out  1  1 = divide-by-zero or timeout; valid with rsp_valid.
- busy  out  1  high in any state other than IDLE.
- div_start  out  1  one-cycle start pulse to divider.
- div_dividend  out  WIDTH  registered operand to divider.
- div_divisor  out  WIDTH  registered operand to divider.
- div_done  in  1  divider completion pulse.
- div_quot  in  WIDTH  divider quotient, valid with div_done.
- div_rem  in  WIDTH  divider remainder, valid with div_done.

Behaviour:
- Reset (async, reset_a_n=0): state IDLE; all outputs 0 (gnt, rsp_valid, rsp_quot, rsp_rem, rsp_err, busy, div_start, div_dividend, div_divisor); last-grant pointer = 1, so requester 0 wins first.
- Reset mid-operation discards the operation with no response; requesters re-request after reset.

State machine:
- IDLE: if any req bit is set, pick a winner.
  - One request: that requester wins.
  - Both requests: the requester not equal to last-grant wins.
  - Register the winner's operands into div_dividend/div_divisor, set gnt, update last-grant.
  - Winner's divisor == 0: go to RESP with rsp_err=1 and quot = rem = 0; no div_start is issued.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle): div_start=1, then go to WAIT.
- WAIT:
  - div_done=1: capture div_quot/div_rem into rsp_quot/rsp_rem, set rsp_err=0, go to RESP.
  - Otherwise stay in WAIT.
- RESP (1 cycle): rsp_valid[winner]=1; go to IDLE; gnt clears on the next cycle.

Timing and latency:
- Req seen at cycle 0: div_start at cycle 1; if div_done arrives at cycle k, rsp_valid is at cycle k+1.
- Divide-by-zero: rsp_valid at cycle 1.
- No back-to-back issue: at least one IDLE cycle between operations, so a waiting requester gets its grant 1 cycle after the other's RESP.

Boundary conditions:
- div_done outside WAIT (including during ISSUE): ignored.
- req deasserted before response (protocol violation): the operation still completes and pulses rsp_valid.
- rsp_quot/rsp_rem/rsp_err hold their last values between responses.
- div_start is never high for two consecutive cycles.

Optional Feature:
- Macro: DIV_SHARE_ARB_TIMEOUT_EN.
- Defined: WAIT cycle counter of width $clog2(TIMEOUT+1), cleared on entry to WAIT.
  - If TIMEOUT cycles elapse without div_done: go to RESP with rsp_err=1, quot = rem = 0.
  - Sticky output port timeout_flag (1 bit, reset 0) sets at that point and clears only on reset.
  - div_done arriving on the same cycle as the timeout: div_done wins (normal result).
- Undefined: WAIT waits indefinitely; no counter logic and no timeout_flag port.

Decomposition:
- Package div_share_pkg:
  - state encoding constants IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - default WIDTH and TIMEOUT constants.
- One natural sub-module, rr_arb2: 2-requester round-robin picker.
  - Inputs: req, last-grant pointer, enable.
  - Output: one-hot grant; the pointer updates on enable.
- FSM, operand mux/registers and response capture live in the top module.

Test Plan:
- Single request: req=2'b01, dividend0=100, divisor0=7, divider model done 17 cycles after start -> div_start at cycle 1, rsp_valid=2'b01 at cycle 19, quot=14, rem=2, err=0.
- Simultaneous requests after reset: req=2'b11 -> requester 0 served first, requester 1 granted 1 cycle after RESP (dividend1=255, divisor1=16 -> quot=15, rem=15). Repeat with both requests held -> grants alternate 0,1,0,1.
- Divide-by-zero: req=2'b10, divisor1=0 -> no div_start, rsp_valid=2'b10 at cycle 1, err=1, quot=0, rem=0.
- Reset mid-operation: drop reset_a_n during WAIT -> all outputs 0 immediately, no rsp_valid; the next request is served normally and requester 0 has priority.
- Stray div_done pulsed in IDLE and in ISSUE -> ignored, no response; the true done later in WAIT produces exactly one rsp_valid.
- With DIV_SHARE_ARB_TIMEOUT_EN: divider model never asserts done, TIMEOUT=40 -> rsp_valid 40 cycles after WAIT entry with err=1, timeout_flag=1 and staying 1; a subsequent normal op returns err=0.

Source files
------------

// File: rtl/div_share_pkg.sv
// Shared types and defaults for the two-requester divider arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package div_share_pkg;

    // Arbiter FSM encoding; values are fixed so waveforms decode consistently.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Default operand width (the divider iterates once per bit).
    localparam int DEF_WIDTH   = 16;
    // Default watchdog limit in WAIT cycles; must exceed the divider latency.
    localparam int DEF_TIMEOUT = 40;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker with an internal last-grant pointer.
// Latency: grant is combinational from req; pointer updates on the enabled edge.
// Backpressure: none; a grant is produced only while enable is high.
//
// Ports:
//   clk, reset_a_n : clock and async active-low reset (pointer resets to 1)
//   req            : request levels
//   en             : commit the current pick and advance the pointer
//   gnt            : one-hot pick (zero when en is low or no request)
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_a_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    // Index of the most recent winner. Reset to 1 so requester 0 wins first.
    logic last_gnt;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Contention: whoever did not win last time goes now.
                2'b11:   gnt = last_gnt ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) begin
            last_gnt <= 1'b1;
        end else if (en && (req != 2'b00)) begin
            last_gnt <= gnt[1];
        end
    end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one multi-cycle divider between two requesters (round-robin), screens divide-by-zero.
// Latency: req at cycle 0 -> div_start at 1; div_done at k -> rsp_valid at k+1; div-by-zero -> rsp_valid at 1.
// Backpressure: requesters hold req/operands until their rsp_valid; one op in flight, one IDLE cycle between ops.
//
// Ports:
//   clk, reset_a_n                : clock, async active-low reset
//   req[1:0]                      : request levels
//   dividend0/divisor0, dividend1/divisor1 : per-requester operands
//   gnt[1:0]                      : one-hot grant, held from ISSUE through RESP
//   rsp_valid[1:0]                : one-cycle response pulse to the winner
//   rsp_quot, rsp_rem, rsp_err    : response data, held between responses
//   busy                          : high whenever not IDLE
//   div_start, div_dividend, div_divisor : divider launch interface
//   div_done, div_quot, div_rem   : divider completion interface
//   timeout_flag                  : sticky watchdog indicator (only with DIV_SHARE_ARB_TIMEOUT_EN)
//
// Build option: define DIV_SHARE_ARB_TIMEOUT_EN to add a WAIT watchdog of TIMEOUT cycles.
module div_share_arbiter
    import div_share_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             reset_a_n,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] dividend0,
    input  logic [WIDTH-1:0] divisor0,
    input  logic [WIDTH-1:0] dividend1,
    input  logic [WIDTH-1:0] divisor1,
    output logic [1:0]       gnt,
    output logic [1:0]       rsp_valid,
    output logic [WIDTH-1:0] rsp_quot,
    output logic [WIDTH-1:0] rsp_rem,
    output logic             rsp_err,
    output logic             busy,
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
    output logic             timeout_flag,
`endif
    output logic             div_start,
    output logic [WIDTH-1:0] div_dividend,
    output logic [WIDTH-1:0] div_divisor,
    input  logic             div_done,
    input  logic [WIDTH-1:0] div_quot,
    input  logic [WIDTH-1:0] div_rem
);

    state_t           state;
    logic [1:0]       pick;
    logic [WIDTH-1:0] sel_dividend;
    logic [WIDTH-1:0] sel_divisor;

`ifdef DIV_SHARE_ARB_TIMEOUT_EN
    localparam int            CW       = $clog2(TIMEOUT + 1);
    // Count value on the last WAIT cycle allowed before the abort.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0]            wait_cnt;
`endif

    // Picker only commits while IDLE so the pointer moves once per operation.
    rr_arb2 u_arb (
        .clk       (clk),
        .reset_a_n (reset_a_n),
        .req       (req),
        .en        (state == IDLE),
        .gnt       (pick)
    );

    always_comb begin
        sel_dividend = pick[1] ? dividend1 : dividend0;
        sel_divisor  = pick[1] ? divisor1  : divisor0;
    end

    always_ff @(posedge clk or negedge reset_a_n) begin
        if (!reset_a_n) begin
            state        <= IDLE;
            gnt          <= 2'b00;
            rsp_valid    <= 2'b00;
            rsp_quot     <= '0;
            rsp_rem      <= '0;
            rsp_err      <= 1'b0;
            busy         <= 1'b0;
            div_start    <= 1'b0;
            div_dividend <= '0;
            div_divisor  <= '0;
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
`endif
        end else begin
            // Pulses default low; only the states below raise them for one cycle.
            div_start <= 1'b0;
            rsp_valid <= 2'b00;

            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        gnt          <= pick;
                        busy         <= 1'b1;
                        div_dividend <= sel_dividend;
                        div_divisor  <= sel_divisor;
                        if (sel_divisor == '0) begin
                            // Answer locally; the divider is never started.
                            rsp_valid <= pick;
                            rsp_err   <= 1'b1;
                            rsp_quot  <= '0;
                            rsp_rem   <= '0;
                            state     <= RESP;
                        end else begin
                            // Raised here so the pulse lines up with the ISSUE cycle.
                            div_start <= 1'b1;
                            state     <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= WAIT;
                end

                WAIT: begin
                    // A done on the same cycle as the watchdog expiry takes priority.
                    if (div_done) begin
                        rsp_quot  <= div_quot;
                        rsp_rem   <= div_rem;
                        rsp_err   <= 1'b0;
                        rsp_valid <= gnt;
                        state     <= RESP;
                    end
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
                    else if (wait_cnt == CNT_LAST) begin
                        rsp_quot     <= '0;
                        rsp_rem      <= '0;
                        rsp_err      <= 1'b1;
                        rsp_valid    <= gnt;
                        timeout_flag <= 1'b1;
                        state        <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
`endif
                end

                RESP: begin
                    gnt   <= 2'b00;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_share_arbiter.sv
// Self-checking bench for div_share_arbiter: transaction-level reference model plus directed cases.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_div_share_arbiter;

    localparam int W   = 16;
    localparam int TMO = 40;

    logic         clk = 1'b0;
    logic         reset_a_n = 1'b0;
    logic [1:0]   req = 2'b00;
    logic [W-1:0] dividend0 = '0, divisor0 = '0, dividend1 = '0, divisor1 = '0;
    logic [1:0]   gnt, rsp_valid;
    logic [W-1:0] rsp_quot, rsp_rem;
    logic         rsp_err, busy, div_start;
    logic [W-1:0] div_dividend, div_divisor;
    logic         div_done = 1'b0;
    logic [W-1:0] div_quot = '0, div_rem = '0;
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
    logic         timeout_flag;
`endif

    div_share_arbiter #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .reset_a_n    (reset_a_n),
        .req          (req),
        .dividend0    (dividend0),
        .divisor0     (divisor0),
        .dividend1    (dividend1),
        .divisor1     (divisor1),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_quot     (rsp_quot),
        .rsp_rem      (rsp_rem),
        .rsp_err      (rsp_err),
        .busy         (busy),
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
        .timeout_flag (timeout_flag),
`endif
        .div_start    (div_start),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_done     (div_done),
        .div_quot     (div_quot),
        .div_rem      (div_rem)
    );

    always #5 clk = ~clk;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got === exp) passes++;
        else $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    endtask

    // Reference model: one operation record, timings derived from arrival cycle.
    bit           act = 0;
    int           who = 0, s_t = 0, rsp_t = 0;
    bit           m_zero = 0, m_tmo = 0;
    bit           last_ptr = 1;
    logic [W-1:0] m_q = '0, m_r = '0, m_opd = '0, m_opv = '0;
    logic [W-1:0] h_q = '0, h_r = '0;
    logic         h_e = 0, h_tof = 0;

    // Divider environment.
    int           lat = 17;
    bit           no_done = 0;
    int           stray_cyc = -1;
    bit           dpend = 0;
    int           dt = 0;
    logic [W-1:0] dq = '0, dr = '0;

    // Observed responses.
    int           rsp_cnt = 0, start_cnt = 0, last_rsp_cyc = 0, last_start_cyc = 0;
    logic [1:0]   last_vld = 0;
    logic [W-1:0] last_q = 0, last_r = 0;
    logic         last_e = 0;
    int           winners[$];

    bit           in_op, e_start;
    logic [1:0]   e_gnt, e_vld;

    always @(negedge clk) begin
        if (!reset_a_n) begin
            act = 0; last_ptr = 1; h_q = '0; h_r = '0; h_e = 0; h_tof = 0;
            dpend = 0; m_opd = '0; m_opv = '0;
        end
        in_op   = reset_a_n && act && (cyc > s_t) && (cyc <= rsp_t);
        e_gnt   = in_op ? (who ? 2'b10 : 2'b01) : 2'b00;
        e_start = in_op && !m_zero && (cyc == s_t + 1);
        e_vld   = (in_op && cyc == rsp_t) ? e_gnt : 2'b00;
        if (e_vld != 2'b00) begin
            h_q = m_q; h_r = m_r; h_e = m_zero || m_tmo;
            if (m_tmo) h_tof = 1;
        end
        chk("gnt", gnt, e_gnt);
        chk("busy", busy, in_op);
        chk("div_start", div_start, e_start);
        chk("rsp_valid", rsp_valid, e_vld);
        chk("rsp_quot", rsp_quot, h_q);
        chk("rsp_rem", rsp_rem, h_r);
        chk("rsp_err", rsp_err, h_e);
        chk("div_dividend", div_dividend, m_opd);
        chk("div_divisor", div_divisor, m_opv);
`ifdef DIV_SHARE_ARB_TIMEOUT_EN
        chk("timeout_flag", timeout_flag, h_tof);
`endif

        if (rsp_valid != 2'b00) begin
            rsp_cnt++; last_rsp_cyc = cyc; last_vld = rsp_valid;
            last_q = rsp_quot; last_r = rsp_rem; last_e = rsp_err;
            winners.push_back(rsp_valid[1] ? 1 : 0);
        end
        if (div_start) begin start_cnt++; last_start_cyc = cyc; end

        div_done = 0; div_quot = '0; div_rem = '0;
        if (reset_a_n) begin
            if (div_start && !no_done && div_divisor != 0) begin
                dpend = 1; dt = cyc + lat;
                dq = div_dividend / div_divisor; dr = div_dividend % div_divisor;
            end
            if (dpend && cyc == dt) begin
                div_done = 1; div_quot = dq; div_rem = dr; dpend = 0;
            end else if (cyc == stray_cyc) begin
                div_done = 1; div_quot = 16'hDEAD; div_rem = 16'hBEEF;
            end

            if (act && cyc == rsp_t) begin
                act = 0;
            end else if (!act && req != 2'b00) begin
                who      = (req == 2'b11) ? (last_ptr ? 0 : 1) : (req[1] ? 1 : 0);
                last_ptr = who[0];
                act      = 1;
                s_t      = cyc;
                m_opd    = who ? dividend1 : dividend0;
                m_opv    = who ? divisor1  : divisor0;
                m_zero   = (m_opv == 0);
                m_tmo    = 0;
                if (m_zero) begin
                    rsp_t = cyc + 1; m_q = '0; m_r = '0;
                end else if (no_done) begin
                    rsp_t = cyc + 2 + TMO; m_tmo = 1; m_q = '0; m_r = '0;
                end else begin
                    rsp_t = cyc + 2 + lat; m_q = m_opd / m_opv; m_r = m_opd % m_opv;
                end
            end
        end
        cyc++;
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(int n0, string name);
        int k = 0;
        while (rsp_cnt <= n0 && k < 300) begin
            tick(1);
            k++;
        end
        total++;
        if (rsp_cnt > n0) passes++;
        else $display("FAIL %s no response within bound got=%0d exp>%0d", name, rsp_cnt, n0);
    endtask

    int base, n, sc;

    initial begin
        reset_a_n = 0;
        tick(3);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_quot", rsp_quot, 0);
        reset_a_n = 1;
        tick(2);

        // Single request, 100/7 with a 17-cycle divider.
        dividend0 = 100; divisor0 = 7; dividend1 = 255; divisor1 = 16; lat = 17;
        n = rsp_cnt; req = 2'b01; base = cyc;
        wait_rsp(n, "t1_rsp");
        req = 2'b00;
        chk("t1_start_cyc", last_start_cyc - base, 1);
        chk("t1_rsp_cyc", last_rsp_cyc - base, 19);
        chk("t1_model_rsp_cyc", rsp_t - base, 19);
        chk("t1_vld", last_vld, 2'b01);
        chk("t1_quot", last_q, 14);
        chk("t1_model_quot", m_q, 14);
        chk("t1_rem", last_r, 2);
        chk("t1_err", last_e, 0);

        // Both requesting after reset: 0 first, then alternate.
        tick(2); reset_a_n = 0; tick(2); reset_a_n = 1; tick(1);
        winners.delete();
        n = rsp_cnt; req = 2'b11;
        wait_rsp(n, "t2_rsp0");
        chk("t2_vld0", last_vld, 2'b01);
        chk("t2_quot0", last_q, 14);
        wait_rsp(n + 1, "t2_rsp1");
        chk("t2_vld1", last_vld, 2'b10);
        chk("t2_quot1", last_q, 15);
        chk("t2_rem1", last_r, 15);
        wait_rsp(n + 2, "t2_rsp2");
        wait_rsp(n + 3, "t2_rsp3");
        req = 2'b00;
        for (int i = 0; i < 4; i++)
            chk($sformatf("t2_winner%0d", i), (i < winners.size()) ? winners[i] : 9, i % 2);

        // Divide by zero on requester 1.
        tick(2);
        divisor1 = 0; sc = start_cnt; n = rsp_cnt; req = 2'b10; base = cyc;
        wait_rsp(n, "t3_rsp");
        req = 2'b00;
        chk("t3_rsp_cyc", last_rsp_cyc - base, 1);
        chk("t3_vld", last_vld, 2'b10);
        chk("t3_err", last_e, 1);
        chk("t3_quot", last_q, 0);
        chk("t3_rem", last_r, 0);
        chk("t3_no_start", start_cnt, sc);
        divisor1 = 16;

        // Reset while the divider is busy.
        tick(2);
        req = 2'b01;
        tick(6);
        n = rsp_cnt;
        reset_a_n = 0;
        #1;
        chk("t4_gnt", gnt, 0);
        chk("t4_busy", busy, 0);
        chk("t4_dividend", div_dividend, 0);
        tick(2); req = 2'b00; tick(1); reset_a_n = 1; tick(3);
        chk("t4_no_rsp", rsp_cnt, n);
        req = 2'b11;
        wait_rsp(n, "t4_rsp");
        req = 2'b00;
        chk("t4_vld", last_vld, 2'b01);

        // Stray div_done in IDLE and ISSUE.
        tick(2);
        n = rsp_cnt;
        stray_cyc = cyc;
        tick(3);
        chk("t5_idle_stray", rsp_cnt, n);
        req = 2'b01; base = cyc; stray_cyc = base + 1;
        wait_rsp(n, "t5_rsp");
        req = 2'b00;
        tick(3);
        chk("t5_single_rsp", rsp_cnt, n + 1);
        chk("t5_quot", last_q, 14);
        chk("t5_rsp_cyc", last_rsp_cyc - base, 19);
        stray_cyc = -1;

`ifdef DIV_SHARE_ARB_TIMEOUT_EN
        // Divider never completes: watchdog abort, then a normal op.
        tick(2);
        no_done = 1; n = rsp_cnt; req = 2'b01; base = cyc;
        wait_rsp(n, "t6_rsp");
        req = 2'b00; no_done = 0;
        chk("t6_rsp_cyc", last_rsp_cyc - base, 42);
        chk("t6_err", last_e, 1);
        chk("t6_flag", timeout_flag, 1);
        tick(3);
        n = rsp_cnt; req = 2'b01;
        wait_rsp(n, "t6_rsp2");
        req = 2'b00;
        chk("t6_err2", last_e, 0);
        chk("t6_flag_sticky", timeout_flag, 1);
`endif

        tick(3);
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
